// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, serial line levels and a
// counter-width helper used by the transmitter and receiver blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        WAIT   = 3'd5
    } uart_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_burst_if.sv
// Per-byte valid/ready handshake between the byte source and the UART
// burst transmitter, including the burst length sampled at burst start.
interface uart_tx_burst_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 10
) ();

    logic [CNT_W-1:0]     bytes_to_tx;
    logic [DATA_BITS-1:0] tx_data_byte;
    logic                 tx_data_valid;
    logic                 tx_ready;

    modport master (
        output bytes_to_tx,
        output tx_data_byte,
        output tx_data_valid,
        input  tx_ready
    );

    modport slave (
        input  bytes_to_tx,
        input  tx_data_byte,
        input  tx_data_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: reloads on i_load and pulses o_bit_end on the last
// enabled cycle of each CLKS_PER_BIT-long bit, then reloads automatically.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_bit_end
);

    localparam int            CNT_BITS = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_BITS-1:0] RELOAD = CNT_BITS'(CLKS_PER_BIT - 1);

    logic [CNT_BITS-1:0] r_cnt;
    logic                w_at_zero;

    assign w_at_zero = (r_cnt == '0);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flops.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_enable) begin
            r_cnt <= w_at_zero ? RELOAD : r_cnt - 1'b1;
        end
    end

    assign o_bit_end = i_enable && w_at_zero;

endmodule

// File: rtl/uart_tx_burst.sv
// Parametrised burst UART transmitter with per-byte valid/ready handshake.
// Optional parity bit is built when UART_TX_PARITY_EN is defined.
module uart_tx_burst
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 2,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1,
    parameter int CNT_W        = 10
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic          clock,
    input  logic          reset_n,
    uart_tx_burst_if.slave s_if,
    output logic          tx_busy,
    output logic          burst_done,
    output logic          serial_data_out
);

    localparam int                 BIT_W     = cnt_width(DATA_BITS);
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          r_state;
    uart_state_e          w_next_state;
    logic                 r_ready_en;
    logic                 r_burst_done;
    logic                 r_stop_idx;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [CNT_W-1:0]     r_remaining;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_ready;
    logic w_xfer;
    logic w_timer_en;
    logic w_bit_end;
    logic w_data_bit;
    logic w_last_bit;
    logic w_last_stop;
    logic w_burst_end;
    logic w_line;

    // Ready is withheld for one cycle after reset releases.
    assign w_ready     = r_ready_en && ((r_state == IDLE) || (r_state == WAIT));
    assign w_xfer      = s_if.tx_data_valid && w_ready;
    assign w_timer_en  = (r_state != IDLE) && (r_state != WAIT);
    assign w_data_bit  = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];
    assign w_last_bit  = w_bit_end && (r_bit_idx == LAST_BIT);
    assign w_last_stop = w_bit_end && (r_stop_idx == LAST_STOP);
    assign w_burst_end = w_last_stop && (r_remaining == '0);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_xfer),
        .i_enable  (w_timer_en),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_line       = LINE_IDLE;
        case (r_state)
            IDLE, WAIT: begin
                if (w_xfer) begin
                    w_next_state = START;
                end
            end
            START: begin
                w_line = LINE_START;
                if (w_bit_end) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                w_line = w_data_bit;
                if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_line = r_parity;
                if (w_bit_end) begin
                    w_next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (w_last_stop) begin
                    w_next_state = (r_remaining == '0) ? IDLE : WAIT;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ready_en   <= 1'b0;
            r_burst_done <= 1'b0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_remaining  <= '0;
        end else begin
            r_ready_en   <= 1'b1;
            r_burst_done <= (r_state == STOP) && w_burst_end;
            if (w_xfer) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                // Burst length is only taken at the first byte of a burst.
                if (r_state == IDLE) begin
                    r_remaining <= s_if.bytes_to_tx;
                end
            end else if (w_bit_end) begin
                if (r_state == DATA) begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
                if (r_state == STOP) begin
                    r_stop_idx <= ~r_stop_idx;
                    if (w_last_stop && (r_remaining != '0)) begin
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: the shift register has no reset; its contents are don't-care
    // until a handshake loads it, and the FSM never reads it before that.
    always_ff @(posedge clock) begin
        if (w_xfer) begin
            r_shift <= s_if.tx_data_byte;
`ifdef UART_TX_PARITY_EN
            r_parity <= (^s_if.tx_data_byte) ^ (PARITY_ODD != 0);
`endif
        end else if (w_bit_end && (r_state == DATA)) begin
            if (MSB_FIRST != 0) begin
                r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
            end else begin
                r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    assign s_if.tx_ready   = w_ready;
    assign tx_busy         = (r_state != IDLE);
    assign burst_done      = r_burst_done;
    assign serial_data_out = w_line;

endmodule

// File: tb/tb_uart_tx_burst.sv
// Randomised bench for uart_tx_burst: two configurations share a clock and a
// queue-based line model; UART_TX_PARITY_EN also adds the parity bit here.
module tb_uart_tx_burst;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sel;
    logic [9:0] tb_bytes;
    logic [7:0] tb_data;
    logic       tb_valid;

    always #5 clock = ~clock;

    uart_tx_burst_if #(.DATA_BITS(8), .CNT_W(10)) if_a ();
    uart_tx_burst_if #(.DATA_BITS(8), .CNT_W(10)) if_b ();

    assign if_a.bytes_to_tx   = tb_bytes;
    assign if_a.tx_data_byte  = tb_data;
    assign if_a.tx_data_valid = tb_valid && !sel;
    assign if_b.bytes_to_tx   = tb_bytes;
    assign if_b.tx_data_byte  = tb_data;
    assign if_b.tx_data_valid = tb_valid && sel;

    logic busy_a, done_a, line_a;
    logic busy_b, done_b, line_b;

    // A: 4 clocks/bit, MSB first, 1 stop bit
    uart_tx_burst #(
        .DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FIRST(1), .CNT_W(10)
    ) u_dut_a (
        .clock           (clock),
        .reset_n         (reset_n),
        .s_if            (if_a),
        .tx_busy         (busy_a),
        .burst_done      (done_a),
        .serial_data_out (line_a)
    );

    // B: 1 clock/bit, LSB first, 2 stop bits (odd parity when enabled)
    uart_tx_burst #(
        .DATA_BITS(8), .CLKS_PER_BIT(1), .STOP_BITS(2), .MSB_FIRST(0), .CNT_W(10)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1)
`endif
    ) u_dut_b (
        .clock           (clock),
        .reset_n         (reset_n),
        .s_if            (if_b),
        .tx_busy         (busy_b),
        .burst_done      (done_b),
        .serial_data_out (line_b)
    );

    logic obs_line, obs_ready, obs_busy, obs_done;
    assign obs_line  = sel ? line_b       : line_a;
    assign obs_ready = sel ? if_b.tx_ready : if_a.tx_ready;
    assign obs_busy  = sel ? busy_b       : busy_a;
    assign obs_done  = sel ? done_b       : done_a;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected line level per cycle, plus burst bookkeeping.
    bit exp_q[$];
    bit m_in_burst     = 1'b0;
    bit m_last_pending = 1'b0;
    bit m_done_next    = 1'b0;
    bit m_rst_prev     = 1'b0;
    bit m_xfer         = 1'b0;
    int m_left         = 0;

    function automatic void push_frame(input logic [7:0] d);
        bit bits[$];
        int cpb   = sel ? 1 : 4;
        int stops = sel ? 2 : 1;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(sel ? d[i] : d[7-i]);
        end
`ifdef UART_TX_PARITY_EN
        bits.push_back((^d) ^ sel);
`endif
        for (int i = 0; i < stops; i++) begin
            bits.push_back(1'b1);
        end
        foreach (bits[i]) begin
            for (int k = 0; k < cpb; k++) begin
                exp_q.push_back(bits[i]);
            end
        end
    endfunction

    always @(negedge clock) begin
        logic e_line, e_ready, e_busy, e_done;
        if (!m_rst_prev) begin
            exp_q.delete();
            m_in_burst     = 1'b0;
            m_last_pending = 1'b0;
            m_done_next    = 1'b0;
            e_line  = 1'b1;
            e_ready = 1'b0;
            e_busy  = 1'b0;
            e_done  = 1'b0;
        end else begin
            e_ready     = (exp_q.size() == 0);
            e_busy      = (exp_q.size() != 0) || m_in_burst;
            e_done      = m_done_next;
            m_done_next = 1'b0;
            if (exp_q.size() != 0) begin
                e_line = exp_q.pop_front();
                if (exp_q.size() == 0 && m_last_pending) begin
                    m_done_next    = 1'b1;
                    m_in_burst     = 1'b0;
                    m_last_pending = 1'b0;
                end
            end else begin
                e_line = 1'b1;
            end
        end
        check("serial_data_out", obs_line,  e_line);
        check("tx_ready",        obs_ready, e_ready);
        check("tx_busy",         obs_busy,  e_busy);
        check("burst_done",      obs_done,  e_done);

        m_xfer = reset_n && e_ready && tb_valid;
        if (m_xfer) begin
            if (!m_in_burst) begin
                m_in_burst = 1'b1;
                m_left     = int'(tb_bytes) + 1;
            end
            m_left--;
            m_last_pending = (m_left == 0);
            push_frame(tb_data);
        end
        m_rst_prev = reset_n;
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
    endtask

    // bytes < 0 re-randomises bytes_to_tx every cycle while waiting.
    task automatic send(input logic [7:0] d, input int bytes, input int gap);
        bit ok = 1'b0;
        tb_valid = 1'b0;
        repeat (gap) cycle();
        tb_valid = 1'b1;
        tb_data  = d;
        for (int w = 0; w < 300 && !ok; w++) begin
            tb_bytes = (bytes < 0) ? 10'($urandom_range(0, 3)) : bytes[9:0];
            cycle();
            ok = m_xfer;
        end
        tb_valid = 1'b0;
        tb_data  = 8'($urandom_range(0, 255));
        check("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 9);
            int g = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 5) : $urandom_range(30, 60);
            send(8'($urandom_range(0, 255)), -1, g);
            if ($urandom_range(0, 24) == 0) begin
                idle($urandom_range(1, 30));
                pulse_reset();
            end
        end
    endtask

    initial begin
        sel      = 1'b0;
        reset_n  = 1'b0;
        tb_valid = 1'b0;
        tb_data  = 8'h00;
        tb_bytes = 10'd0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(5);

        send(8'hA5, 0, 0);
        idle(50);

        send(8'h01, 2, 0);
        send(8'h80, 2, 0);
        send(8'hFF, 2, 50);
        idle(50);

        send(8'h5A, 0, 0);
        idle(17);
        pulse_reset();
        send(8'h3C, 0, 0);
        idle(50);

        random_traffic(200);

        pulse_reset();
        sel = 1'b1;
        idle(3);
        send(8'h03, 0, 0);
        idle(20);
        send(8'h07, 1, 0);
        send(8'h07, 1, 0);
        idle(20);

        random_traffic(200);
        idle(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
